// File: rtl/vga_pkg.sv
// Shared timing types, 640x480@60 defaults and helpers for the VGA timing generator.
package vga_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] front;
    logic [15:0] sync;
    logic [15:0] back;
  } vga_axis_t;

  localparam int unsigned VGA_CLK_DIV  = 2;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;

  localparam vga_axis_t VGA_H_640 = '{active: 16'd640, front: 16'd16, sync: 16'd96, back: 16'd48};
  localparam vga_axis_t VGA_V_480 = '{active: 16'd480, front: 16'd10, sync: 16'd2,  back: 16'd33};

  function automatic int unsigned total(input vga_axis_t a);
    return 32'(a.active) + 32'(a.front) + 32'(a.sync) + 32'(a.back);
  endfunction

  // Counter width that never collapses to zero bits for degenerate ranges.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus active/sync/last decodes.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter vga_axis_t   AXIS = VGA_H_640,
  parameter int unsigned W    = cnt_width(total(AXIS))
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         step_i,
  output logic [W-1:0] count,
  output logic         last,
  output logic         sync_act,
  output logic         active
);

  localparam int unsigned TOTAL    = total(AXIS);
  localparam int unsigned SYNC_BEG = 32'(AXIS.active) + 32'(AXIS.front);
  localparam int unsigned SYNC_END = SYNC_BEG + 32'(AXIS.sync);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (step_i) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

  assign last     = (count == W'(TOTAL - 1));
  assign sync_act = (32'(count) >= SYNC_BEG) && (32'(count) < SYNC_END);
  assign active   = (32'(count) < 32'(AXIS.active));

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-rate divider, h/v axis counters and
// a registered output stage carrying coordinates, syncs and update strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT    = VGA_H_FRONT,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BACK     = VGA_H_BACK,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT    = VGA_V_FRONT,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BACK     = VGA_V_BACK,
  parameter logic        H_SYNC_POL = 1'b0,
  parameter logic        V_SYNC_POL = 1'b0,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10
) (
  input  logic           clk_i,
  input  logic           rst_i,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic [X_W-1:0] pixel_x_o,
  output logic [Y_W-1:0] pixel_y_o,
  output logic           visible_range_o,
  output logic           px_valid_o,
  output logic           line_start_o,
  output logic           frame_start_o,
  output logic           vblank_start_o
);

  localparam vga_axis_t H_AXIS = '{active: 16'(H_ACTIVE), front: 16'(H_FRONT),
                                   sync: 16'(H_SYNC), back: 16'(H_BACK)};
  localparam vga_axis_t V_AXIS = '{active: 16'(V_ACTIVE), front: 16'(V_FRONT),
                                   sync: 16'(V_SYNC), back: 16'(V_BACK)};
  localparam int unsigned H_TOTAL = total(H_AXIS);
  localparam int unsigned V_TOTAL = total(V_AXIS);
  localparam int unsigned HW      = cnt_width(H_TOTAL);
  localparam int unsigned VW      = cnt_width(V_TOTAL);
  localparam int unsigned DIV_W   = cnt_width(CLK_DIV);

  generate
    if (CLK_DIV < 1) begin : g_div_chk
      $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (X_W < 32'($clog2(H_TOTAL))) begin : g_xw_chk
      $error("vga_timing_gen: X_W too narrow for H_TOTAL");
    end
    if (Y_W < 32'($clog2(V_TOTAL))) begin : g_yw_chk
      $error("vga_timing_gen: Y_W too narrow for V_TOTAL");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;
  logic             px_en;

  // With CLK_DIV = 1 the counter stays at 0 and px_en is permanently high.
  assign px_en = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= px_en ? '0 : div_cnt + 1'b1;
    end
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, h_sync_act, h_active;
  logic          v_last_unused, v_sync_act, v_active;

  vga_axis_counter #(.AXIS(H_AXIS), .W(HW)) u_h_axis (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .step_i   (px_en),
    .count    (h_cnt),
    .last     (h_last),
    .sync_act (h_sync_act),
    .active   (h_active)
  );

  vga_axis_counter #(.AXIS(V_AXIS), .W(VW)) u_v_axis (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .step_i   (px_en && h_last),
    .count    (v_cnt),
    .last     (v_last_unused),
    .sync_act (v_sync_act),
    .active   (v_active)
  );

  logic h_first, v_first, v_vblank;

  assign h_first  = (h_cnt == '0);
  assign v_first  = (v_cnt == '0);
  assign v_vblank = (v_cnt == VW'(V_ACTIVE));

  // Outputs sample the pre-increment position, so they lag the counters by one px_en.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pixel_x_o       <= '0;
      pixel_y_o       <= '0;
      visible_range_o <= 1'b0;
      hsync_o         <= ~H_SYNC_POL;
      vsync_o         <= ~V_SYNC_POL;
      px_valid_o      <= 1'b0;
      line_start_o    <= 1'b0;
      frame_start_o   <= 1'b0;
      vblank_start_o  <= 1'b0;
    end else begin
      px_valid_o     <= px_en;
      line_start_o   <= px_en && h_first;
      frame_start_o  <= px_en && h_first && v_first;
      vblank_start_o <= px_en && h_first && v_vblank;
      if (px_en) begin
        pixel_x_o       <= X_W'(h_cnt);
        pixel_y_o       <= Y_W'(v_cnt);
        visible_range_o <= h_active && v_active;
        hsync_o         <= h_sync_act ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_o         <= v_sync_act ? V_SYNC_POL : ~V_SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default mode (first lines), tiny CLK_DIV=1 mode, CLK_DIV=3 mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // DUT A: defaults (CLK_DIV=2, 800x525)
  logic       a_rst, a_hs, a_vs, a_vis, a_val, a_ls, a_fs, a_vb;
  logic [9:0] a_x, a_y;
  vga_timing_gen u_a (
    .clk_i(clk), .rst_i(a_rst), .hsync_o(a_hs), .vsync_o(a_vs),
    .pixel_x_o(a_x), .pixel_y_o(a_y), .visible_range_o(a_vis),
    .px_valid_o(a_val), .line_start_o(a_ls), .frame_start_o(a_fs),
    .vblank_start_o(a_vb)
  );

  // DUT B: CLK_DIV=1, H 8/2/2/2 (14), V 4/1/1/1 (7), hsync active-high
  logic       b_rst, b_hs, b_vs, b_vis, b_val, b_ls, b_fs, b_vb;
  logic [3:0] b_x;
  logic [2:0] b_y;
  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .X_W(4), .Y_W(3)
  ) u_b (
    .clk_i(clk), .rst_i(b_rst), .hsync_o(b_hs), .vsync_o(b_vs),
    .pixel_x_o(b_x), .pixel_y_o(b_y), .visible_range_o(b_vis),
    .px_valid_o(b_val), .line_start_o(b_ls), .frame_start_o(b_fs),
    .vblank_start_o(b_vb)
  );

  // DUT C: CLK_DIV=3, H 20/4/4/4 (32), V 10/2/2/2 (16)
  logic       c_rst, c_hs, c_vs, c_vis, c_val, c_ls, c_fs, c_vb;
  logic [4:0] c_x;
  logic [3:0] c_y;
  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(20), .H_FRONT(4), .H_SYNC(4), .H_BACK(4),
    .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .X_W(5), .Y_W(4)
  ) u_c (
    .clk_i(clk), .rst_i(c_rst), .hsync_o(c_hs), .vsync_o(c_vs),
    .pixel_x_o(c_x), .pixel_y_o(c_y), .visible_range_o(c_vis),
    .px_valid_o(c_val), .line_start_o(c_ls), .frame_start_o(c_fs),
    .vblank_start_o(c_vb)
  );

  initial begin
    int first_val, n_val, n_double, n_hs, n_hs_bad, first_hs_x, n_vs, n_vs_bad;
    int n_vis, n_ls, n_ls_per_bad, n_fs, n_fs_per_bad, n_vb, n_vb_bad;
    int n_strobe_bad, n_gap, n_wrap, n_oor, last_ls, last_fs;
    logic prev_val, prev_fs;
    int prev_x, prev_y;
    logic found;

    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    repeat (3) @(negedge clk);

    check_eq("a_rst_x",   a_x,   0);
    check_eq("a_rst_y",   a_y,   0);
    check_eq("a_rst_vis", a_vis, 0);
    check_eq("a_rst_hs",  a_hs,  1);
    check_eq("a_rst_vs",  a_vs,  1);
    check_eq("a_rst_val", a_val, 0);
    check_eq("a_rst_strobes", {a_ls, a_fs, a_vb}, 0);
    check_eq("b_rst_hs",  b_hs,  0);
    check_eq("b_rst_vs",  b_vs,  1);

    // ---------------- DUT A: three lines at default timing ----------------
    a_rst = 1'b0;
    first_val = -1; n_val = 0; n_double = 0; n_hs = 0; n_hs_bad = 0; first_hs_x = -1;
    n_vs = 0; n_vis = 0; n_ls = 0; n_ls_per_bad = 0; n_fs = 0; n_vb = 0;
    n_strobe_bad = 0; last_ls = -1; prev_val = 1'b0;
    for (int cyc = 0; cyc <= 4801; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (a_val) begin
        if (first_val < 0) begin
          first_val = cyc;
          check_eq("a_first_x",  a_x,  0);
          check_eq("a_first_y",  a_y,  0);
          check_eq("a_first_vis", a_vis, 1);
          check_eq("a_first_fs", a_fs, 1);
          check_eq("a_first_ls", a_ls, 1);
        end
        n_val++;
        if (prev_val) n_double++;
        if (!a_hs) begin
          n_hs++;
          if (a_x < 656 || a_x >= 752) n_hs_bad++;
          if (first_hs_x < 0) first_hs_x = int'(a_x);
        end
        if (!a_vs) n_vs++;
        if (a_vis) n_vis++;
      end
      if ((a_ls || a_fs || a_vb) && !a_val) n_strobe_bad++;
      if (a_ls) begin
        if (last_ls >= 0 && cyc - last_ls != 1600) n_ls_per_bad++;
        last_ls = cyc;
        n_ls++;
      end
      if (a_fs) n_fs++;
      if (a_vb) n_vb++;
      prev_val = a_val;
    end
    check_eq("a_first_valid_cycle", first_val, 2);
    check_eq("a_valid_count", n_val, 2400);
    check_eq("a_valid_width", n_double, 0);
    check_eq("a_hsync_low_count", n_hs, 288);
    check_eq("a_hsync_low_range", n_hs_bad, 0);
    check_eq("a_hsync_first_x", first_hs_x, 656);
    check_eq("a_vsync_low", n_vs, 0);
    check_eq("a_visible_count", n_vis, 1920);
    check_eq("a_line_starts", n_ls, 3);
    check_eq("a_line_period", n_ls_per_bad, 0);
    check_eq("a_frame_starts", n_fs, 1);
    check_eq("a_vblank_starts", n_vb, 0);
    check_eq("a_strobe_without_valid", n_strobe_bad, 0);

    // ---------------- DUT B: two full frames, CLK_DIV=1 ----------------
    b_rst = 1'b0;
    first_val = -1; n_val = 0; n_gap = 0; n_hs = 0; n_hs_bad = 0; n_vs = 0; n_vs_bad = 0;
    n_vis = 0; n_ls = 0; n_fs = 0; n_fs_per_bad = 0; n_vb = 0; n_vb_bad = 0;
    n_wrap = 0; n_oor = 0; n_double = 0; last_fs = -1; prev_fs = 1'b0;
    prev_x = -1; prev_y = -1;
    for (int cyc = 0; cyc <= 196; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (b_val) begin
        if (first_val < 0) begin
          first_val = cyc;
          check_eq("b_first_fs", b_fs, 1);
          check_eq("b_first_xy", {b_x, b_y}, 0);
        end
        n_val++;
        if (b_x > 13 || b_y > 6) n_oor++;
        if (b_hs) begin
          if (b_x == 10 || b_x == 11) n_hs++; else n_hs_bad++;
        end
        if (!b_vs) begin
          if (b_y == 5) n_vs++; else n_vs_bad++;
        end
        if (b_vis) n_vis++;
        if (b_ls) n_ls++;
        if (b_vb) begin
          n_vb++;
          if (b_y != 4) n_vb_bad++;
        end
        if (prev_x == 13 && prev_y == 6 && b_fs && b_ls && b_x == 0 && b_y == 0) n_wrap++;
        prev_x = int'(b_x);
        prev_y = int'(b_y);
      end else if (first_val >= 0) begin
        n_gap++;
      end
      if (b_fs) begin
        if (prev_fs) n_double++;
        if (last_fs >= 0 && cyc - last_fs != 98) n_fs_per_bad++;
        last_fs = cyc;
        n_fs++;
      end
      prev_fs = b_fs;
    end
    check_eq("b_first_valid_cycle", first_val, 1);
    check_eq("b_valid_count", n_val, 196);
    check_eq("b_valid_gaps", n_gap, 0);
    check_eq("b_hsync_high_in_range", n_hs, 28);
    check_eq("b_hsync_high_out_range", n_hs_bad, 0);
    check_eq("b_vsync_low_in_range", n_vs, 28);
    check_eq("b_vsync_low_out_range", n_vs_bad, 0);
    check_eq("b_visible_count", n_vis, 64);
    check_eq("b_line_starts", n_ls, 14);
    check_eq("b_frame_starts", n_fs, 2);
    check_eq("b_frame_period", n_fs_per_bad, 0);
    check_eq("b_frame_start_width", n_double, 0);
    check_eq("b_vblank_starts", n_vb, 2);
    check_eq("b_vblank_row", n_vb_bad, 0);
    check_eq("b_wrap_events", n_wrap, 1);
    check_eq("b_out_of_range", n_oor, 0);

    // ---------------- DUT C: mid-frame reset with CLK_DIV=3 ----------------
    c_rst = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
      @(negedge clk);
      if (c_val && c_x == 5 && c_y == 3) found = 1'b1;
    end
    check_eq("c_reach_x5_y3", found, 1);
    c_rst = 1'b1;
    @(negedge clk);
    check_eq("c_mid_rst_xy",  {c_x, c_y}, 0);
    check_eq("c_mid_rst_vis", c_vis, 0);
    check_eq("c_mid_rst_sync", {c_hs, c_vs}, 3);
    check_eq("c_mid_rst_strobes", {c_val, c_ls, c_fs, c_vb}, 0);
    c_rst = 1'b0;
    first_val = -1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      if (c_val && first_val < 0) begin
        first_val = cyc;
        check_eq("c_restart_xy", {c_x, c_y}, 0);
        check_eq("c_restart_fs", c_fs, 1);
        check_eq("c_restart_vis", c_vis, 1);
      end
    end
    check_eq("c_restart_valid_cycle", first_val, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator that replaces the fixed-mode, macro-configured generator. It derives a pixel-rate enable from the board clock and counts pixels and lines against fully parametrised horizontal and vertical timing. It drives sync outputs of selectable polarity, pixel coordinates and the visible-range flag. It also emits per-pixel valid, line-start, frame-start and vblank-start strobes, which the pong game logic and renderer use as update ticks.

## Interface
- CLK_DIV, 2, board clocks per pixel (≥1); 50 MHz board / 25 MHz pixel
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync active level (0 = active-low)
- V_SYNC_POL, 0, vsync active level
- X_W, 10, pixel_x_o width; elaboration error if X_W < $clog2(H_TOTAL)
- Y_W, 10, pixel_y_o width; elaboration error if Y_W < $clog2(V_TOTAL)

Ports:
- clk_i  in  1  board clock
- rst_i  in  1  reset, synchronous, active-high
- hsync_o  out  1  horizontal sync at H_SYNC_POL when active
- vsync_o  out  1  vertical sync at V_SYNC_POL when active
- pixel_x_o  out  X_W  horizontal count of the current pixel
- pixel_y_o  out  Y_W  vertical count of the current pixel
- visible_range_o  out  1  current pixel is inside the active area
- px_valid_o  out  1  one-cycle pulse: outputs were updated this cycle
- line_start_o  out  1  one-cycle pulse, coincident with px_valid_o, when x = 0
- frame_start_o  out  1  one-cycle pulse when x = 0 and y = 0
- vblank_start_o  out  1  one-cycle pulse when x = 0 and y = V_ACTIVE

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL likewise (525).
- HSYNC active for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC), i.e. [656,752). VSYNC active for v in [490,492).
- Divider div_cnt counts 0..CLK_DIV-1 and wraps to 0. px_en = (div_cnt == CLK_DIV-1). With CLK_DIV = 1, px_en is constantly 1.
- On px_en, h_cnt increments and wraps from H_TOTAL-1 to 0. v_cnt increments only on px_en with h_cnt == H_TOTAL-1, and wraps from V_TOTAL-1 to 0.
- On px_en, all outputs register decodes of the pre-increment (h_cnt, v_cnt):
  - pixel_x_o = h_cnt and pixel_y_o = v_cnt, zero-extended.
  - visible_range_o = h<H_ACTIVE && v<V_ACTIVE.
  - sync levels from the decodes above.
  - strobes from the conditions listed in Interface.
- px_valid_o is high on the cycle after px_en. All strobes are cleared on every cycle without px_en, so each is exactly one clk wide.
- Between enables, coordinate, sync and visible outputs hold their value.

## Timing
- Reset values:
  - div_cnt, h_cnt, v_cnt = 0
  - pixel_x_o = pixel_y_o = 0
  - visible_range_o = 0
  - hsync_o = ~H_SYNC_POL, vsync_o = ~V_SYNC_POL (inactive)
  - all strobes = 0
- After reset deasserts (first cycle = cycle 0), the first px_en occurs in cycle CLK_DIV-1. Outputs show x=0, y=0, visible=1, with px_valid_o, line_start_o and frame_start_o high in cycle CLK_DIV.
- Output latency is one clk after the px_en cycle. Outputs show the position as it stood at that px_en.
- Reset asserted mid-frame clears everything on the next edge and restarts exactly as from power-up. No partial strobe is emitted.
- Line period = H_TOTAL·CLK_DIV clk cycles. Frame period = H_TOTAL·V_TOTAL·CLK_DIV = 840000 clk cycles at the defaults.
- At the frame wrap (h = 799, v = 524), the next px_en yields frame_start_o and line_start_o together.

## Structure
- vga_pkg holds:
  - localparams for the 640x480@60 defaults
  - typedef struct packed vga_axis_t {active, front, sync, back} used to group per-axis timing
  - the function total(vga_axis_t)
- Sub-module vga_axis_counter is instanced twice, for h and v:
  - ports: clk_i, rst_i, step_i, count, last, sync_act, active
  - parametrised by vga_axis_t
- The divider and output register stage stay in vga_timing_gen.

## Test plan
- Defaults, free-run one frame → px_valid_o count = 420000; hsync_o low for exactly 96 consecutive px_valid_o per line, beginning at pixel_x_o = 656; vsync_o low while pixel_y_o ∈ {490, 491}.
- Defaults → line_start_o every 1600 clk; frame_start_o every 840000 clk; vblank_start_o once per frame, with pixel_y_o = 480; visible_range_o high for 307200 valid pixels per frame.
- Release reset → first px_valid_o in cycle 2 with x=0, y=0, frame_start_o=1; pulses exactly one clk wide.
- Small mode CLK_DIV=1 (H 8/2/2/2, V 4/1/1/1), H_SYNC_POL=1 → px_valid_o constantly high; hsync_o high only at x ∈ {10, 11}; frame length 98 clk.
- CLK_DIV=3, reset asserted at x=300, y=200 for one cycle → next cycle outputs at reset values; first valid at cycle 3 after release shows x=0, y=0.
- Wrap check → the sequence (799,524) then (0,0) has frame_start_o and line_start_o asserted together; no out-of-range coordinates ever appear.
